ysyx_220066_div_iter: RTL and testbench
=======================================

YSYX_220066_DIV_ITER -- requirements
Module: ysyx_220066_div_iter

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and result width (32 or 64).
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1, quotient bits retired per iteration (1, 2 or 4; must divide 32).
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset (low = reset).
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  divider can accept a request.
REQ-007 SHALL have port src1  input  XLEN  dividend.
REQ-008 SHALL have port src2  input  XLEN  divisor.
REQ-009 SHALL have port op  input  2  00 div, 01 divu, 10 rem, 11 remu.
REQ-010 SHALL have port is_w  input  1  32-bit word op (ignored when XLEN=32).
REQ-011 SHALL have port flush  input  1  kill in-flight op (pipeline redirect).
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port result  output  XLEN  quotient or remainder.

Function
REQ-015 SHALL implement states IDLE, PREP, CALC, DONE.
REQ-016 SHALL drive in_ready = (state==IDLE) && !flush; accept when in_valid && in_ready at a rising edge; operands and op latched at accept.
REQ-017 SHALL on a normal accept go IDLE->PREP (1 cycle: take absolute values, select width) -> CALC for ITER = W/BITS_PER_CYCLE cycles, where W = 32 if is_w, else XLEN -> DONE.
REQ-018 SHALL therefore raise out_valid exactly ITER+2 cycles after the accept edge (66 cycles for 64-bit, BITS_PER_CYCLE=1).
REQ-019 SHALL handle a zero divisor by skipping PREP/CALC and entering DONE on the next edge (out_valid 1 cycle after accept): quotient = all ones, remainder = dividend.
REQ-020 SHALL handle signed overflow (dividend = -2^(W-1), divisor = -1, op div/rem) by the same 1-cycle path: quotient = dividend, remainder = 0.
REQ-021 SHALL, for signed ops, negate the quotient when operand signs differ and give the remainder the dividend's sign.
REQ-022 SHALL, for is_w, sign-extend (div/rem) or zero-extend (divu/remu) src1[31:0] and src2[31:0] to form operands, and sign-extend result bit 31 to XLEN.
REQ-023 SHALL hold out_valid and result stable in DONE until out_ready is high at a rising edge, then return to IDLE; in_ready is low in DONE (no back-to-back overlap).
REQ-024 SHALL, on flush high at a rising edge, enter IDLE from any state and clear out_valid; flush takes priority over out_ready and over a new accept.
REQ-025 SHALL keep result at its previous value outside DONE; result is only valid when out_valid is high.

Reset
REQ-026 SHALL, while rst is low, force state IDLE, out_valid 0, result 0, iteration counter 0, independent of clk.
REQ-027 SHALL treat reset deassertion mid-operation as a fresh start: no result from the aborted op is ever presented.

Structure
REQ-028 SHALL place op encodings, state encoding and the ITER computation in shared package ysyx_220066_div_pkg.
REQ-029 SHALL implement one restoring-division step as sub-module ysyx_220066_div_step, instantiated BITS_PER_CYCLE times in a chain inside CALC.

Verification
REQ-030 SHALL cover: XLEN=64, div src1=-7, src2=2 -> out_valid 66 cycles after accept, result=-3 (0xFFFF_FFFF_FFFF_FFFD); rem same operands -> -1.
REQ-031 SHALL cover: divu src2=0, src1=0x1234 -> out_valid 1 cycle after accept, result=0xFFFF_FFFF_FFFF_FFFF; remu -> 0x1234.
REQ-032 SHALL cover: is_w div src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF -> 1-cycle path, result=0xFFFF_FFFF_8000_0000; remw -> 0.
REQ-033 SHALL cover: flush asserted at CALC cycle 10 -> state IDLE next edge, out_valid never rises, in_ready 1 the following cycle; next op divu 100/7 returns 14.
REQ-034 SHALL cover: out_ready held low 5 cycles in DONE -> result and out_valid stable all 5 cycles; in_ready 0 throughout.
REQ-035 SHALL cover: BITS_PER_CYCLE=2, XLEN=64, divu 0xFFFF_FFFF_FFFF_FFFF/3 -> out_valid 34 cycles after accept, result=0x5555_5555_5555_5555; rst pulled low mid-CALC -> out_valid 0 immediately.

Source files
------------

// File: rtl/ysyx_220066_div_pkg.sv
// Shared definitions for the iterative integer divider.
//   div_op_e    : operation encoding on the op port (div, divu, rem, remu).
//   div_state_e : control FSM states.
//   iter_count  : number of CALC cycles for a given width / radix.
package ysyx_220066_div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    CALC = 2'b10,
    DONE = 2'b11
  } div_state_e;

  // Wide enough to hold 64 (64-bit operands, one bit per cycle).
  localparam int CNT_W = 7;

  function automatic logic [CNT_W-1:0] iter_count(input int xlen, input int bpc,
                                                  input logic is_w);
    int w;
    w = is_w ? 32 : xlen;
    return CNT_W'(w / bpc);
  endfunction

endpackage

// File: rtl/ysyx_220066_div_step.sv
// One restoring-division step on unsigned magnitudes.
//   rem_i / quo_i : partial remainder and dividend/quotient shift register
//   div_i         : divisor magnitude
//   rem_o / quo_o : state after retiring one quotient bit
// The next dividend bit is taken from the top of quo_i; the new quotient
// bit enters at the bottom of quo_o.
module ysyx_220066_div_step
  import ysyx_220066_div_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // rem_i < div_i always holds, so shifted < 2*div_i and the restored or
  // subtracted value fits back into XLEN bits.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign diff    = shifted - {1'b0, div_i};
  assign rem_o   = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/ysyx_220066_div_iter.sv
// Iterative signed/unsigned divider with valid/ready handshakes.
//   clk, rst (async, active-low)
//   in_valid/in_ready, src1 (dividend), src2 (divisor), op, is_w : request
//   flush     : abort any operation and return to IDLE
//   out_valid/out_ready, result : quotient or remainder
// Zero divisor and signed overflow bypass the iteration and finish in one
// cycle. Word ops extend 32-bit operands and sign-extend the 32-bit result.
module ysyx_220066_div_iter
  import ysyx_220066_div_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      op,
  input  logic            is_w,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] ONES = '1;

  // Extend the low word to XLEN when w is set (sign or zero), else pass x.
  function automatic logic [XLEN-1:0] ext_word(input logic [XLEN-1:0] x,
                                               input logic w, input logic sgn);
    logic [XLEN-1:0] r;
    r = x;
    if (w) begin
      for (int i = 32; i < XLEN; i++) r[i] = sgn & x[31];
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                              input logic sgn);
    logic signed [XLEN-1:0] s;
    s = $signed(x);
    if (sgn && (s < 0)) s = -s;
    return $unsigned(s);
  endfunction

  // Apply operand signs to the unsigned quotient/remainder and fit to width.
  function automatic logic [XLEN-1:0] sign_fix(input logic [XLEN-1:0] q,
                                               input logic [XLEN-1:0] r,
                                               input logic [1:0] opc,
                                               input logic a_neg, input logic b_neg,
                                               input logic w);
    logic                   sgn;
    logic signed [XLEN-1:0] v;
    sgn = ~opc[0];
    if (opc[1]) v = (sgn && a_neg) ? -$signed(r) : $signed(r);
    else        v = (sgn && (a_neg ^ b_neg)) ? -$signed(q) : $signed(q);
    return ext_word($unsigned(v), w, 1'b1);
  endfunction

  function automatic logic [XLEN-1:0] special_res(input logic [XLEN-1:0] a,
                                                  input logic [1:0] opc,
                                                  input logic zero, input logic w);
    logic [XLEN-1:0] v;
    if (zero) v = opc[1] ? a : ONES;
    else      v = opc[1] ? '0 : a;
    return ext_word(v, w, 1'b1);
  endfunction

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] a_q, b_q;
  logic [1:0]      op_q;
  logic            w_q;
  logic [XLEN-1:0] rem_q, quo_q, div_q;

  logic            accept;
  logic            w_in, sgn_in, zero_in, ovf_in;
  logic [XLEN-1:0] a_in, b_in, min_in;
  logic [XLEN-1:0] final_res;

  logic [XLEN-1:0] rem_c [BITS_PER_CYCLE+1];
  logic [XLEN-1:0] quo_c [BITS_PER_CYCLE+1];

  assign in_ready  = (state_q == IDLE) && !flush;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign accept    = in_valid && in_ready;

  // Accept stage: operand extension and single-cycle special cases
  assign w_in    = (XLEN > 32) && is_w;
  assign sgn_in  = ~op[0];
  assign a_in    = ext_word(src1, w_in, sgn_in);
  assign b_in    = ext_word(src2, w_in, sgn_in);
  assign min_in  = ONES << (w_in ? 31 : XLEN - 1);
  assign zero_in = (b_in == '0);
  assign ovf_in  = sgn_in && (a_in == min_in) && (b_in == ONES);

  // CALC stage: BITS_PER_CYCLE chained restoring steps
  assign rem_c[0] = rem_q;
  assign quo_c[0] = quo_q;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    ysyx_220066_div_step #(.XLEN(XLEN)) u_step (
      .rem_i (rem_c[g]),
      .quo_i (quo_c[g]),
      .div_i (div_q),
      .rem_o (rem_c[g+1]),
      .quo_o (quo_c[g+1])
    );
  end

  assign final_res = sign_fix(quo_c[BITS_PER_CYCLE], rem_c[BITS_PER_CYCLE], op_q,
                              a_q[XLEN-1], b_q[XLEN-1], w_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (zero_in || ovf_in) begin
            state_d  = DONE;
            result_d = special_res(a_in, op, zero_in, w_in);
          end else begin
            state_d = PREP;
          end
        end
      end
      PREP: begin
        state_d = CALC;
        cnt_d   = iter_count(XLEN, BITS_PER_CYCLE, w_q);
      end
      CALC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A redirect overrides both completion handshake and new work.
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath registers: latched at accept, prepared in PREP, iterated in CALC
  always_ff @(posedge clk) begin
    if ((state_q == IDLE) && accept) begin
      a_q  <= a_in;
      b_q  <= b_in;
      op_q <= op;
      w_q  <= w_in;
    end
    if (state_q == PREP) begin
      rem_q <= '0;
      // Word dividends are left-justified so 32 steps consume exactly them.
      quo_q <= w_q ? (abs_val(a_q, ~op_q[0]) << (XLEN - 32)) : abs_val(a_q, ~op_q[0]);
      div_q <= abs_val(b_q, ~op_q[0]);
    end
    if (state_q == CALC) begin
      rem_q <= rem_c[BITS_PER_CYCLE];
      quo_q <= quo_c[BITS_PER_CYCLE];
    end
  end

endmodule

// File: tb/tb_ysyx_220066_div_iter.sv
module tb_ysyx_220066_div_iter;

  logic        clk = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        d1_rst, d1_in_valid, d1_in_ready, d1_is_w, d1_flush;
  logic        d1_out_valid, d1_out_ready;
  logic [63:0] d1_src1, d1_src2, d1_result;
  logic [1:0]  d1_op;

  logic        d2_rst, d2_in_valid, d2_in_ready, d2_is_w, d2_flush;
  logic        d2_out_valid, d2_out_ready;
  logic [63:0] d2_src1, d2_src2, d2_result;
  logic [1:0]  d2_op;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  ysyx_220066_div_iter #(.XLEN(64), .BITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(d1_rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .src1(d1_src1), .src2(d1_src2), .op(d1_op), .is_w(d1_is_w), .flush(d1_flush),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .result(d1_result)
  );

  ysyx_220066_div_iter #(.XLEN(64), .BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(d2_rst), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .src1(d2_src1), .src2(d2_src2), .op(d2_op), .is_w(d2_is_w), .flush(d2_flush),
    .out_valid(d2_out_valid), .out_ready(d2_out_ready), .result(d2_result)
  );

  // Issue one request; lat counts edges from the accept edge (inclusive)
  // until out_valid is seen. Optionally consume the result afterwards.
  task automatic run_op(input bit sel, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b,
                        input bit consume, output int lat, output logic [63:0] res);
    @(negedge clk);
    if (!sel) begin
      d1_op = op; d1_is_w = w; d1_src1 = a; d1_src2 = b; d1_in_valid = 1'b1;
    end else begin
      d2_op = op; d2_is_w = w; d2_src1 = a; d2_src2 = b; d2_in_valid = 1'b1;
    end
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    d2_in_valid = 1'b0;
    lat = 1;
    while (!(sel ? d2_out_valid : d1_out_valid) && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    res = sel ? d2_result : d1_result;
    if (consume) begin
      if (!sel) d1_out_ready = 1'b1; else d2_out_ready = 1'b1;
      @(posedge clk); #1;
      d1_out_ready = 1'b0;
      d2_out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    d1_rst = 1'b0; d2_rst = 1'b0;
    d1_in_valid = 0; d1_is_w = 0; d1_flush = 0; d1_out_ready = 0;
    d1_src1 = '0; d1_src2 = '0; d1_op = 2'b00;
    d2_in_valid = 0; d2_is_w = 0; d2_flush = 0; d2_out_ready = 0;
    d2_src1 = '0; d2_src2 = '0; d2_op = 2'b00;
    #22;
    n_tests++;
    if (d1_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b want 0", d1_out_valid);
    end
    n_tests++;
    if (d1_result !== 64'h0) begin
      n_fail++; $display("FAIL reset_result: got %h want 0", d1_result);
    end
    n_tests++;
    if (d1_in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", d1_in_ready);
    end
    @(negedge clk);
    d1_rst = 1'b1; d2_rst = 1'b1;
  endtask

  task automatic test_signed_div();
    int lat; logic [63:0] res;
    run_op(0, 2'b00, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, lat, res);
    n_tests++;
    if (lat !== 66) begin n_fail++; $display("FAIL div_lat: got %0d want 66", lat); end
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL div_-7_2: got %h want fffffffffffffffd", res);
    end
    run_op(0, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, lat, res);
    n_tests++;
    if (res !== ALL1) begin n_fail++; $display("FAIL rem_-7_2: got %h want ffffffffffffffff", res); end
    run_op(0, 2'b00, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, lat, res);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL div_7_-2: got %h want fffffffffffffffd", res);
    end
    run_op(0, 2'b10, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1, lat, res);
    n_tests++;
    if (res !== 64'd1) begin n_fail++; $display("FAIL rem_7_-2: got %h want 1", res); end
  endtask

  task automatic test_div_zero();
    int lat; logic [63:0] res;
    run_op(0, 2'b01, 0, 64'h1234, 64'h0, 1, lat, res);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL divz_lat: got %0d want 1", lat); end
    n_tests++;
    if (res !== ALL1) begin n_fail++; $display("FAIL divu_zero: got %h want all ones", res); end
    run_op(0, 2'b11, 0, 64'h1234, 64'h0, 1, lat, res);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL remz_lat: got %0d want 1", lat); end
    n_tests++;
    if (res !== 64'h1234) begin n_fail++; $display("FAIL remu_zero: got %h want 1234", res); end
  endtask

  task automatic test_word();
    int lat; logic [63:0] res;
    run_op(0, 2'b00, 1, 64'h0000_0000_8000_0000, ALL1, 1, lat, res);
    n_tests++;
    if (lat !== 1) begin n_fail++; $display("FAIL divw_ovf_lat: got %0d want 1", lat); end
    n_tests++;
    if (res !== 64'hFFFF_FFFF_8000_0000) begin
      n_fail++; $display("FAIL divw_ovf: got %h want ffffffff80000000", res);
    end
    run_op(0, 2'b10, 1, 64'h0000_0000_8000_0000, ALL1, 1, lat, res);
    n_tests++;
    if (res !== 64'h0) begin n_fail++; $display("FAIL remw_ovf: got %h want 0", res); end
    run_op(0, 2'b01, 1, 64'hABCD_0000_0000_0064, 64'h1111_0000_0000_0007, 1, lat, res);
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL divuw_lat: got %0d want 34", lat); end
    n_tests++;
    if (res !== 64'd14) begin n_fail++; $display("FAIL divuw_100_7: got %h want e", res); end
    run_op(0, 2'b00, 1, 64'h0000_0000_FFFF_FFF9, 64'd2, 1, lat, res);
    n_tests++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      n_fail++; $display("FAIL divw_-7_2: got %h want fffffffffffffffd", res);
    end
  endtask

  task automatic test_flush();
    int lat; logic [63:0] res; bit seen;
    @(negedge clk);
    d1_op = 2'b01; d1_is_w = 0; d1_src1 = 64'd1000; d1_src2 = 64'd3; d1_in_valid = 1'b1;
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    d1_flush = 1'b1;
    #1;
    n_tests++;
    if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready_calc: got %b want 0", d1_in_ready); end
    @(posedge clk); #1;
    d1_flush = 1'b0;
    #1;
    n_tests++;
    if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle: in_ready got %b want 1", d1_in_ready); end
    seen = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (d1_out_valid) seen = 1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_valid: out_valid rose=%b want 0", seen); end
    run_op(0, 2'b01, 0, 64'd100, 64'd7, 1, lat, res);
    n_tests++;
    if (lat !== 66) begin n_fail++; $display("FAIL post_flush_lat: got %0d want 66", lat); end
    n_tests++;
    if (res !== 64'd14) begin n_fail++; $display("FAIL post_flush_divu: got %h want e", res); end
  endtask

  task automatic test_hold();
    int lat; logic [63:0] res;
    run_op(0, 2'b01, 0, 64'd50, 64'd5, 0, lat, res);
    n_tests++;
    if (res !== 64'd10) begin n_fail++; $display("FAIL hold_first: got %h want a", res); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (d1_out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b want 1", i, d1_out_valid); end
      n_tests++;
      if (d1_result !== 64'd10) begin n_fail++; $display("FAIL hold_result[%0d]: got %h want a", i, d1_result); end
      n_tests++;
      if (d1_in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b want 0", i, d1_in_ready); end
    end
    @(negedge clk);
    d1_out_ready = 1'b1;
    @(posedge clk); #1;
    d1_out_ready = 1'b0;
    n_tests++;
    if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release_valid: got %b want 0", d1_out_valid); end
    n_tests++;
    if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release_ready: got %b want 1", d1_in_ready); end
    n_tests++;
    if (d1_result !== 64'd10) begin n_fail++; $display("FAIL hold_keep_result: got %h want a", d1_result); end
  endtask

  task automatic test_bpc2();
    int lat; logic [63:0] res; bit seen;
    run_op(1, 2'b01, 0, ALL1, 64'd3, 1, lat, res);
    n_tests++;
    if (lat !== 34) begin n_fail++; $display("FAIL bpc2_lat: got %0d want 34", lat); end
    n_tests++;
    if (res !== 64'h5555_5555_5555_5555) begin
      n_fail++; $display("FAIL bpc2_divu: got %h want 5555555555555555", res);
    end
    @(negedge clk);
    d2_op = 2'b01; d2_is_w = 0; d2_src1 = 64'd1000; d2_src2 = 64'd3; d2_in_valid = 1'b1;
    @(posedge clk); #1;
    d2_in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    d2_rst = 1'b0;
    #1;
    n_tests++;
    if (d2_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b want 0", d2_out_valid); end
    n_tests++;
    if (d2_result !== 64'h0) begin n_fail++; $display("FAIL rst_mid_result: got %h want 0", d2_result); end
    n_tests++;
    if (d2_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", d2_in_ready); end
    @(negedge clk);
    d2_rst = 1'b1;
    seen = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (d2_out_valid) seen = 1;
    end
    n_tests++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_valid: out_valid rose=%b want 0", seen); end
    run_op(1, 2'b01, 0, 64'd100, 64'd7, 1, lat, res);
    n_tests++;
    if (res !== 64'd14) begin n_fail++; $display("FAIL bpc2_after_rst: got %h want e", res); end
  endtask

  initial begin
    test_reset();
    test_signed_div();
    test_div_zero();
    test_word();
    test_flush();
    test_hold();
    test_bpc2();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
